// File: rtl/imm_decode_stage.sv
// imm_decode_stage: pipelined immediate decoder with 2-entry skid buffer; define IMM_DECODE_ZICSR_EN for Zicsr CSR-immediate (type Z) decode
module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter bit RV64_OPS = (XLEN == 64)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_type_o,
  output logic            out_illegal_o
);
  localparam int W = 36 + 2 * XLEN;
  localparam bit RV64 = RV64_OPS && (XLEN == 64);
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [2:0] typ;
  logic ill;
  logic [W-1:0] beat, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic push, pop;
  assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
  assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8], 1'b0};
  assign imm_u = {in_instr_i[31:12], 12'b0};
  assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21], 1'b0};
  // classify the opcode and pick the matching 32-bit immediate; illegal encodings report R with imm 0
  always_comb begin
    imm32 = '0;
    typ = 3'd0;
    ill = 1'b0;
    case (in_instr_i[6:2])
      5'b00000, 5'b00011, 5'b00100, 5'b11001: begin typ = 3'd1; imm32 = imm_i; end
      5'b11100: begin
        typ = 3'd1;
        imm32 = imm_i;
`ifdef IMM_DECODE_ZICSR_EN
        if (in_instr_i[14] && in_instr_i[13:12] != 2'b00) begin typ = 3'd6; imm32 = {27'd0, in_instr_i[19:15]}; end
`endif
      end
      5'b00110: begin typ = 3'd1; imm32 = imm_i; ill = !RV64; end
      5'b01000: begin typ = 3'd2; imm32 = imm_s; end
      5'b11000: begin typ = 3'd3; imm32 = imm_b; end
      5'b00101, 5'b01101: begin typ = 3'd4; imm32 = imm_u; end
      5'b11011: begin typ = 3'd5; imm32 = imm_j; end
      5'b01100: typ = 3'd0;
      5'b01110: ill = !RV64;
      default: ill = 1'b1;
    endcase
    if (in_instr_i[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin imm32 = '0; typ = 3'd0; end
  end
  assign beat = {in_instr_i, in_pc_i, XLEN'($signed(imm32)), typ, ill};
  assign push = in_valid_i && !skid_v_q;
  assign pop = main_v_q && out_ready_i;
  // skid-buffer steering: flush beats pop beats push; data only moves when an entry is (re)loaded
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (pop && skid_v_q) begin
      main_d = skid_q;
      skid_v_d = 1'b0;
    end else if (pop) begin
      main_v_d = push;
      main_d = push ? beat : main_q;
    end else if (push && main_v_q) begin
      skid_d = beat;
      skid_v_d = 1'b1;
    end else if (push) begin
      main_d = beat;
      main_v_d = 1'b1;
    end
  end
  // buffer state registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign in_ready_o = !skid_v_q;
  assign out_valid_o = main_v_q;
  assign {out_instr_o, out_pc_o, out_imm_o, out_type_o, out_illegal_o} = main_q;
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Parametrised, pipelined immediate-decode stage for the decode pipeline; successor to the combinational immediate generator.
- Classifies the instruction format from the opcode itself and builds the XLEN-wide sign-extended immediate.
- Flags unsupported opcodes as illegal.
- Registers results behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates are sign-extended to XLEN.
- RV64_OPS, (XLEN==64), 1 enables OP-IMM-32/OP-32 opcodes; forced 0 when XLEN=32.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous pipeline flush
- in_valid_i  in  1  upstream instruction valid
- in_ready_o  out  1  stage can accept
- in_instr_i  in  32  raw instruction
- in_pc_i  in  XLEN  instruction PC
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- out_instr_o  out  32  instruction passthrough
- out_pc_o  out  XLEN  PC passthrough
- out_imm_o  out  XLEN  sign-extended immediate
- out_type_o  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, Z=6
- out_illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_i=1): both buffer entries invalid; out_valid_o=0, in_ready_o=1; out_imm_o, out_pc_o, out_instr_o, out_type_o and out_illegal_o all 0.
- Latency: 1 cycle. An instruction accepted at edge N (in_valid_i & in_ready_o) is on the outputs after edge N.
- Throughput: 1 instruction per cycle while out_ready_i=1.
- Buffer: main entry drives the outputs; skid entry catches one beat when the main entry is valid and stalled.
  - in_ready_o = !skid_valid (registered, no combinational path from out_ready_i).
  - Pop (out_valid_o & out_ready_i) while skid valid: skid moves to main.
  - Pop and push in the same cycle with skid empty: new beat goes to main.
  - Push with main valid and no pop: beat goes to skid. in_ready_o drops next cycle.
  - Push is never accepted while skid is full.
- Outputs are held stable while out_valid_o=1 & out_ready_i=0.
- flush_i: on the next edge both entries are invalidated and any same-cycle input is dropped. flush_i has priority over push and pop.
- Opcode decode (instr[6:2]); if instr[1:0]!=2'b11, the opcode is illegal:
  - I-type: LOAD 00000, MISC-MEM 00011, OP-IMM 00100, JALR 11001, SYSTEM 11100.
  - I-type, RV64_OPS only: OP-IMM-32 00110.
  - S-type: STORE 01000.
  - B-type: BRANCH 11000.
  - U-type: AUIPC 00101, LUI 01101.
  - J-type: JAL 11011.
  - R-type, imm=0: OP 01100; OP-32 01110 (RV64_OPS only).
  - Any other opcode: out_illegal_o=1, type R, imm 0.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U = sext({instr[31:12], 12'b0}); on XLEN=64 this fills bits 63:32 with instr[31].
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Passthroughs out_instr_o/out_pc_o travel with their entry unchanged.

Optional Feature:
- Macro IMM_DECODE_ZICSR_EN.
- Defined: SYSTEM with funct3 in {101,110,111} (CSRRWI/CSRRSI/CSRRCI) reports type Z; out_imm_o = zero-extended instr[19:15].
- Undefined: all SYSTEM encodings report type I with sign-extended instr[31:20]; type code 6 is never produced.

Test Plan:
- ADDI 0xFFF00093, out_ready_i=1, XLEN=32: one cycle later out_valid_o=1, type 1, imm 0xFFFFFFFF, illegal 0.
- Back-to-back SW 0x00112623, BEQ 0xFE000EE3, JAL 0x0010006F: consecutive outputs are type 2 imm 0x0000000C, type 3 imm 0xFFFFFFFC, type 5 imm 0x00000800; no bubbles.
- Backpressure: out_ready_i=0 with 3 instructions offered.
  - Two are accepted; in_ready_o=0 from the cycle after the second accept.
  - Outputs hold the first instruction stable.
  - On release, the three emerge in order with no loss or duplication.
- XLEN=64: LUI 0x800000B7 gives imm 0xFFFFFFFF80000000.
- XLEN=32: OP-IMM-32 0x0010009B gives illegal 1, imm 0.
- 0x00000013 with instr[1:0] forced to 00 (0x00000010) gives illegal 1.
- Flush/reset:
  - flush_i while both entries are full and in_valid_i=1: next cycle out_valid_o=0, in_ready_o=1, input dropped.
  - rst_i asserted mid-stream (asynchronously, between edges): outputs go to 0 immediately.
  - Zicsr build: CSRRWI 0x3401D073 gives type 6, imm 0x00000003.
